// File: rtl/dcpu_intc_if.sv
// dcpu data-bus view of the interrupt controller: address/write-data/direction in, read data/select out.
interface dcpu_intc_if;
    logic [15:0] i_addr;
    logic [15:0] i_dat;
    logic        i_rw;
    logic [15:0] o_dat;
    logic        o_sel;

    modport slave  (input  i_addr, input  i_dat, input  i_rw, output o_dat, output o_sel);
    modport master (output i_addr, output i_dat, output i_rw, input  o_dat, input  o_sel);
endinterface

// File: rtl/dcpu_intc.sv
// Memory-mapped interrupt controller: latches, masks and prioritises NSRC request lines
// and holds one request in service until software writes EOI.
module dcpu_intc #(
    parameter int unsigned NSRC      = 8,
    parameter logic [15:0] BASE_ADDR = 16'hff00
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NSRC-1:0]   i_src,
    dcpu_intc_if.slave        bus,
    output logic              o_int
);
    localparam int unsigned AW     = 16;
    localparam int unsigned IW     = 4;
    localparam int unsigned NREG_B = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_e;

    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] edge_q, edge_d;
    logic [NSRC-1:0] src_q;
    logic [IW-1:0]   insvc_q, insvc_d;
    state_e          state_q, state_d;
    logic            int_q, int_d;

    logic [AW:0]     off;
    logic [2:0]      reg_idx;
    logic            wr_en, wr_pend, wr_mask, wr_edge, wr_ack, wr_eoi;
    logic [NSRC-1:0] pm, set, clr;
    logic            vec_valid;
    logic [IW-1:0]   vec_idx;

    // Extra top bit makes addresses below BASE_ADDR land far outside the window.
    assign off       = {1'b0, bus.i_addr} - {1'b0, BASE_ADDR};
    assign bus.o_sel = (off < (AW+1)'(NREG_B));
    assign reg_idx   = off[3:1];
    assign wr_en     = bus.o_sel & ~bus.i_rw;
    assign wr_pend   = wr_en && (reg_idx == 3'd0);
    assign wr_mask   = wr_en && (reg_idx == 3'd1);
    assign wr_edge   = wr_en && (reg_idx == 3'd2);
    assign wr_ack    = wr_en && (reg_idx == 3'd3);
    assign wr_eoi    = wr_en && (reg_idx == 3'd4);

    assign pm  = pending_q & mask_q;
    assign set = i_src & (~edge_q | ~src_q);

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        vec_valid = 1'b0;
        vec_idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pm[i]) begin
                vec_valid = 1'b1;
                vec_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        mask_d    = mask_q;
        edge_d    = edge_q;
        insvc_d   = insvc_q;
        state_d   = state_q;
        clr       = '0;

        if (wr_pend) clr    = bus.i_dat[NSRC-1:0];
        if (wr_mask) mask_d = bus.i_dat[NSRC-1:0];
        if (wr_edge) edge_d = bus.i_dat[NSRC-1:0];

        case (state_q)
            ST_IDLE: if (|pm) state_d = ST_REQ;
            ST_REQ: begin
                if (wr_ack) begin
                    if (vec_valid) begin
                        insvc_d = vec_idx;
                        clr     = clr | (NSRC'(1) << vec_idx);
                        state_d = ST_SVC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!(|pm)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SVC:  if (wr_eoi) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new set in the same cycle as a clear keeps the bit pending.
        pending_d = (pending_q & ~clr) | set;
        int_d     = (state_d == ST_REQ);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pending_q <= '0;
            mask_q    <= '0;
            edge_q    <= '0;
            src_q     <= '0;
            insvc_q   <= '0;
            state_q   <= ST_IDLE;
            int_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            src_q     <= i_src;
            insvc_q   <= insvc_d;
            state_q   <= state_d;
            int_q     <= int_d;
        end
    end

    // Side-effect-free readback; zero outside the window.
    always_comb begin
        bus.o_dat = '0;
        if (bus.o_sel) begin
            case (reg_idx)
                3'd0:    bus.o_dat = 16'(pending_q);
                3'd1:    bus.o_dat = 16'(mask_q);
                3'd2:    bus.o_dat = 16'(edge_q);
                3'd3:    bus.o_dat = {vec_valid, 11'b0, vec_idx};
                3'd4:    bus.o_dat = {state_q, 10'b0, insvc_q};
                default: bus.o_dat = '0;
            endcase
        end
    end

    assign o_int = int_q;
endmodule

// File: tb/tb_dcpu_intc.sv
// Directed table-driven bench for dcpu_intc with hand sequences for reset and decode corners.
module tb_dcpu_intc;
    localparam logic [15:0] BASE = 16'hff00;
    localparam logic [15:0] PEND = 16'h0, MASK = 16'h2, EDGE = 16'h4, VEC = 16'h6, STAT = 16'h8;

    typedef struct packed {
        logic        rw;
        logic [15:0] off;
        logic [15:0] wdat;
        logic [7:0]  src;
        logic        chk_dat;
        logic [15:0] exp_dat;
        logic        chk_int;
        logic        exp_int;
    } row_t;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic [7:0] i_src;
    logic       o_int;
    int         n_chk = 0;
    int         n_pass = 0;
    row_t       vec[$];

    dcpu_intc_if bus();

    dcpu_intc #(.NSRC(8), .BASE_ADDR(BASE)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_src     (i_src),
        .bus       (bus),
        .o_int     (o_int)
    );

    always #5 i_clk = ~i_clk;

    function automatic row_t mk(logic rw, logic [15:0] off, logic [15:0] wdat, logic [7:0] src,
                                logic cd, logic [15:0] d, logic ci, logic i);
        row_t r;
        r.rw = rw; r.off = off; r.wdat = wdat; r.src = src;
        r.chk_dat = cd; r.exp_dat = d; r.chk_int = ci; r.exp_int = i;
        return r;
    endfunction

    function automatic row_t rd(logic [15:0] off, logic [7:0] src, logic [15:0] d);
        return mk(1'b1, off, 16'h0, src, 1'b1, d, 1'b0, 1'b0);
    endfunction
    function automatic row_t rdi(logic [15:0] off, logic [7:0] src, logic [15:0] d, logic i);
        return mk(1'b1, off, 16'h0, src, 1'b1, d, 1'b1, i);
    endfunction
    function automatic row_t wr(logic [15:0] off, logic [15:0] wdat, logic [7:0] src);
        return mk(1'b0, off, wdat, src, 1'b0, 16'h0, 1'b0, 1'b0);
    endfunction
    function automatic row_t nop(logic [7:0] src);
        return mk(1'b1, PEND, 16'h0, src, 1'b0, 16'h0, 1'b0, 1'b0);
    endfunction
    function automatic row_t nopi(logic [7:0] src, logic i);
        return mk(1'b1, PEND, 16'h0, src, 1'b0, 16'h0, 1'b1, i);
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
    endtask

    task automatic drive(input logic rw, input logic [15:0] off, input logic [15:0] wdat);
        bus.i_rw   = rw;
        bus.i_addr = BASE + off;
        bus.i_dat  = wdat;
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic rdchk(input string name, input logic [15:0] off, input logic [15:0] exp);
        drive(1'b1, off, 16'h0);
        #1;
        chk(name, bus.o_dat, exp);
    endtask

    initial begin
        // 1: reset with every source high
        i_reset_n = 1'b0;
        i_src     = 8'hff;
        drive(1'b1, PEND, 16'h0);
        tick; tick;
        chk("rst int", 16'(o_int), 16'h0);
        rdchk("rst pending", PEND, 16'h0);
        rdchk("rst mask", MASK, 16'h0);
        rdchk("rst edge", EDGE, 16'h0);
        rdchk("rst status", STAT, 16'h0);
        // level source re-pends after release but stays masked
        i_reset_n = 1'b1;
        i_src     = 8'h01;
        tick;
        rdchk("relpend", PEND, 16'h0001);
        chk("relpend int", 16'(o_int), 16'h0);
        tick;
        chk("relpend masked int", 16'(o_int), 16'h0);
        i_src = 8'h00;
        drive(1'b0, PEND, 16'h0001);
        tick;
        rdchk("relpend w1c", PEND, 16'h0);
        tick;

        // 2: edge source, ACK, EOI
        vec.push_back(wr(MASK, 16'h0004, 8'h00));
        vec.push_back(wr(EDGE, 16'h0004, 8'h00));
        vec.push_back(nopi(8'h04, 1'b0));
        vec.push_back(rdi(PEND, 8'h00, 16'h0004, 1'b0));
        vec.push_back(rdi(VEC,  8'h00, 16'h8002, 1'b1));
        vec.push_back(wr(VEC, 16'h0000, 8'h00));
        vec.push_back(rdi(STAT, 8'h00, 16'h8002, 1'b0));
        vec.push_back(rd(PEND, 8'h00, 16'h0000));
        vec.push_back(wr(STAT, 16'h0000, 8'h00));
        vec.push_back(rdi(STAT, 8'h00, 16'h0002, 1'b0));
        // 3: priority, lowest index first, second request after EOI
        vec.push_back(wr(MASK, 16'h00ff, 8'h00));
        vec.push_back(wr(EDGE, 16'h00ff, 8'h00));
        vec.push_back(nop(8'h22));
        vec.push_back(rd(PEND, 8'h00, 16'h0022));
        vec.push_back(rdi(VEC,  8'h00, 16'h8001, 1'b1));
        vec.push_back(wr(VEC, 16'h0000, 8'h00));
        vec.push_back(rdi(STAT, 8'h00, 16'h8001, 1'b0));
        vec.push_back(wr(STAT, 16'h0000, 8'h00));
        vec.push_back(rdi(STAT, 8'h00, 16'h0001, 1'b0));
        vec.push_back(rdi(VEC,  8'h00, 16'h8005, 1'b1));
        vec.push_back(wr(VEC, 16'h0000, 8'h00));
        vec.push_back(wr(STAT, 16'h0000, 8'h00));
        vec.push_back(rdi(STAT, 8'h00, 16'h0005, 1'b0));
        // 4: level source, set beats W1C
        vec.push_back(wr(EDGE, 16'h0000, 8'h00));
        vec.push_back(wr(MASK, 16'h0001, 8'h00));
        vec.push_back(nop(8'h01));
        vec.push_back(rd(PEND, 8'h01, 16'h0001));
        vec.push_back(wr(PEND, 16'h0001, 8'h01));
        vec.push_back(rdi(PEND, 8'h01, 16'h0001, 1'b1));
        vec.push_back(wr(PEND, 16'h0001, 8'h00));
        vec.push_back(rdi(PEND, 8'h00, 16'h0000, 1'b1));
        vec.push_back(nopi(8'h00, 1'b0));
        // 5: mask removed while in REQ, then stray ACK in IDLE
        vec.push_back(wr(EDGE, 16'h0008, 8'h00));
        vec.push_back(wr(MASK, 16'h0008, 8'h00));
        vec.push_back(nop(8'h08));
        vec.push_back(nop(8'h00));
        vec.push_back(rdi(VEC, 8'h00, 16'h8003, 1'b1));
        vec.push_back(wr(MASK, 16'h0000, 8'h00));
        vec.push_back(nopi(8'h00, 1'b1));
        vec.push_back(rdi(PEND, 8'h00, 16'h0008, 1'b0));
        vec.push_back(rd(STAT, 8'h00, 16'h0005));
        vec.push_back(wr(VEC, 16'h0000, 8'h00));
        vec.push_back(rdi(STAT, 8'h00, 16'h0005, 1'b0));
        vec.push_back(rd(MASK, 8'h00, 16'h0000));

        foreach (vec[i]) begin
            i_src = vec[i].src;
            drive(vec[i].rw, vec[i].off, vec[i].wdat);
            #2;
            if (vec[i].chk_dat) chk($sformatf("row%0d dat", i), bus.o_dat, vec[i].exp_dat);
            if (vec[i].chk_int) chk($sformatf("row%0d int", i), 16'(o_int), 16'(vec[i].exp_int));
            tick;
        end

        // 6: window decode and ignored address bit 0
        i_src = 8'h00;
        drive(1'b1, 16'h000a, 16'h0);
        #1;
        chk("dec +a sel", 16'(bus.o_sel), 16'h0);
        chk("dec +a dat", bus.o_dat, 16'h0);
        drive(1'b1, 16'hfffe, 16'h0);
        #1;
        chk("dec -2 sel", 16'(bus.o_sel), 16'h0);
        chk("dec -2 dat", bus.o_dat, 16'h0);
        drive(1'b1, STAT, 16'h0);
        #1;
        chk("dec +8 sel", 16'(bus.o_sel), 16'h1);
        drive(1'b0, 16'h0003, 16'h1234);
        tick;
        rdchk("dec odd mask", MASK, 16'h0034);

        // 7: reset during service drops the in-service request
        drive(1'b0, MASK, 16'h0008);
        tick;
        drive(1'b1, PEND, 16'h0);
        tick;
        chk("svc int", 16'(o_int), 16'h1);
        rdchk("svc vec", VEC, 16'h8003);
        drive(1'b0, VEC, 16'h0);
        tick;
        rdchk("svc status", STAT, 16'h8003);
        i_reset_n = 1'b0;
        tick;
        i_reset_n = 1'b1;
        rdchk("svc rst status", STAT, 16'h0000);
        rdchk("svc rst mask", MASK, 16'h0000);
        chk("svc rst int", 16'(o_int), 16'h0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
